// File: rtl/rans_byte_packer_if.sv
// Word stream from the rANS byte packer to the DMA consumer.
// The packer drives the master side. The consumer drives m_ready_i.
interface rans_byte_packer_if #(
  parameter int SYMBOL_WIDTH = 8
);
  logic                      m_valid_o;
  logic [4*SYMBOL_WIDTH-1:0] m_data_o;
  logic [3:0]                m_keep_o;
  logic                      m_last_o;
  logic                      m_ready_i;

  modport master (
    output m_valid_o,
    output m_data_o,
    output m_keep_o,
    output m_last_o,
    input  m_ready_i
  );

  modport slave (
    input  m_valid_o,
    input  m_data_o,
    input  m_keep_o,
    input  m_last_o,
    output m_ready_i
  );
endinterface

// File: rtl/rans_byte_packer.sv
// Packs the encoder byte stream little-endian into 4-byte words with keep/last,
// buffered in a first-word-fall-through FIFO with a sticky overflow flag.
module rans_byte_packer #(
  parameter int SYMBOL_WIDTH = 8,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            valid_i,
  input  logic [SYMBOL_WIDTH-1:0]         enc_i,
  input  logic                            flush_i,
  rans_byte_packer_if.master              m_if,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] level_o,
  output logic                            overflow_o
);
  localparam int SW = SYMBOL_WIDTH;
  localparam int WW = 4 * SYMBOL_WIDTH;
  localparam int EW = WW + 5;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  logic [1:0]    r_cnt;
  logic [SW-1:0] r_pack0, r_pack1, r_pack2;

  logic          w_push;
  logic [WW-1:0] w_data;
  logic [3:0]    w_keep;
  logic          w_last;

  // Every flush emits exactly one word. A byte that arrives with the flush
  // joins the word before it closes.
  always_comb begin
    w_push = (valid_i && (r_cnt == 2'd3)) || flush_i;
    w_last = flush_i;
    w_data = '0;
    w_keep = '0;
    if (r_cnt > 2'd0) begin
      w_data[0 +: SW] = r_pack0;
      w_keep[0]       = 1'b1;
    end
    if (r_cnt > 2'd1) begin
      w_data[SW +: SW] = r_pack1;
      w_keep[1]        = 1'b1;
    end
    if (r_cnt > 2'd2) begin
      w_data[2*SW +: SW] = r_pack2;
      w_keep[2]          = 1'b1;
    end
    if (valid_i) begin
      case (r_cnt)
        2'd0:    begin w_data[0 +: SW]    = enc_i; w_keep[0] = 1'b1; end
        2'd1:    begin w_data[SW +: SW]   = enc_i; w_keep[1] = 1'b1; end
        2'd2:    begin w_data[2*SW +: SW] = enc_i; w_keep[2] = 1'b1; end
        default: begin w_data[3*SW +: SW] = enc_i; w_keep[3] = 1'b1; end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt   <= '0;
      r_pack0 <= '0;
      r_pack1 <= '0;
      r_pack2 <= '0;
    end else begin
      if (w_push) begin
        r_cnt <= '0;
      end else if (valid_i) begin
        r_cnt <= r_cnt + 2'd1;
      end
      if (valid_i && !w_push) begin
        case (r_cnt)
          2'd0:    r_pack0 <= enc_i;
          2'd1:    r_pack1 <= enc_i;
          2'd2:    r_pack2 <= enc_i;
          default: ;
        endcase
      end
    end
  end

  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0] r_count;
  logic          r_overflow;

  logic          w_full, w_empty, w_pop, w_wr;
  logic [EW-1:0] w_head;

  assign w_full  = (r_count == LW'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && m_if.m_ready_i;
  // A pop on the same edge frees a slot, so a push into a full FIFO still fits.
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk_i) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= {w_last, w_keep, w_data};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + LW'(1);
        2'b01:   r_count <= r_count - LW'(1);
        default: ;
      endcase
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  // Storage is not reset, so the head is masked to zero while the FIFO is empty.
  assign m_if.m_valid_o = !w_empty;
  assign {m_if.m_last_o, m_if.m_keep_o, m_if.m_data_o} = w_empty ? '0 : w_head;
  assign level_o    = r_count;
  assign overflow_o = r_overflow;
endmodule

// File: tb/tb_rans_byte_packer.sv
// Scoreboard bench for rans_byte_packer: directed byte/flush vectors push expected
// words; a monitor pops and compares on every output handshake.
module tb_rans_byte_packer;
  localparam int SW    = 8;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid = 1'b0;
  logic          flush = 1'b0;
  logic [SW-1:0] enc = '0;
  logic [LW-1:0] level;
  logic          overflow;
  logic          ready_cfg = 1'b1;
  logic          rand_mode = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  logic [36:0] exp_q[$];

  rans_byte_packer_if #(.SYMBOL_WIDTH(SW)) m_if ();

  rans_byte_packer #(.SYMBOL_WIDTH(SW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .valid_i   (valid),
    .enc_i     (enc),
    .flush_i   (flush),
    .m_if      (m_if),
    .level_o   (level),
    .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Ready is updated mid-low-phase so it is settled well before the next edge.
  initial begin
    m_if.m_ready_i = 1'b1;
    forever begin
      @(negedge clk);
      #2;
      m_if.m_ready_i = rand_mode ? 1'($urandom_range(0, 1)) : ready_cfg;
    end
  end

  // Monitor: sees the head and ready exactly as the next rising edge will.
  logic [36:0] held;
  logic [36:0] cur;
  logic        stalled = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      #3;
      cur = {m_if.m_last_o, m_if.m_keep_o, m_if.m_data_o};
      if (!rst_n || !m_if.m_valid_o) begin
        stalled = 1'b0;
      end else begin
        if (stalled) chk("stable_head", cur, held);
        if (m_if.m_ready_i) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_word: got %0h expected no word", cur);
          end else begin
            chk("word", cur, exp_q.pop_front());
          end
          stalled = 1'b0;
        end else begin
          held    = cur;
          stalled = 1'b1;
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] b, input logic f);
    valid = v;
    enc   = b;
    flush = f;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_word(input logic [7:0] base);
    exp_q.push_back({1'b0, 4'hF, base + 8'd3, base + 8'd2, base + 8'd1, base});
    for (int i = 0; i < 4; i++) drive(1'b1, base + 8'(i), 1'b0);
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || level != 0) && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk({name, "_queue_left"}, exp_q.size(), 0);
    chk({name, "_level"}, level, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", m_if.m_valid_o, 0);
    chk("rst_data", m_if.m_data_o, 0);
    chk("rst_keep", m_if.m_keep_o, 0);
    chk("rst_last", m_if.m_last_o, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    rst_n = 1'b1;

    // back-to-back bytes, latency of one cycle after the 4th byte
    exp_q.push_back({1'b0, 4'hF, 32'h04030201});
    exp_q.push_back({1'b0, 4'hF, 32'h08070605});
    for (int i = 1; i <= 3; i++) drive(1'b1, 8'(i), 1'b0);
    chk("lat_before", m_if.m_valid_o, 0);
    drive(1'b1, 8'h04, 1'b0);
    chk("lat_after", m_if.m_valid_o, 1);
    chk("lat_level", level, 1);
    for (int i = 5; i <= 8; i++) drive(1'b1, 8'(i), 1'b0);
    idle(1);
    wait_drain("b2b");

    // partial flush, next byte restarts at lane 0
    exp_q.push_back({1'b1, 4'b0011, 32'h0000BBAA});
    exp_q.push_back({1'b1, 4'b0001, 32'h000000CC});
    drive(1'b1, 8'hAA, 1'b0);
    drive(1'b1, 8'hBB, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b1, 8'hCC, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    idle(1);
    wait_drain("partial");

    // flush with the 4th byte, flush at cnt=0, flush with a byte at cnt=1
    exp_q.push_back({1'b1, 4'hF, 32'h04030201});
    exp_q.push_back({1'b1, 4'h0, 32'h00000000});
    exp_q.push_back({1'b1, 4'b0011, 32'h00002211});
    exp_q.push_back({1'b1, 4'b0011, 32'h00004433});
    drive(1'b1, 8'h01, 1'b0);
    drive(1'b1, 8'h02, 1'b0);
    drive(1'b1, 8'h03, 1'b0);
    drive(1'b1, 8'h04, 1'b1);
    idle(2);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b1, 8'h11, 1'b0);
    drive(1'b1, 8'h22, 1'b1);
    drive(1'b1, 8'h33, 1'b0);
    drive(1'b1, 8'h44, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    idle(1);
    wait_drain("flush_edges");

    // random backpressure
    rand_mode = 1'b1;
    send_word(8'h20);
    send_word(8'h30);
    idle(2);
    send_word(8'h40);
    exp_q.push_back({1'b1, 4'b0111, 32'h00525150});
    drive(1'b1, 8'h50, 1'b0);
    drive(1'b1, 8'h51, 1'b0);
    drive(1'b1, 8'h52, 1'b1);
    send_word(8'h60);
    idle(20);
    rand_mode = 1'b0;
    ready_cfg = 1'b1;
    wait_drain("backpressure");

    // fill, then push and pop on the same edge at full
    ready_cfg = 1'b0;
    idle(2);
    for (int i = 0; i < DEPTH; i++) send_word(8'(i * 4));
    idle(1);
    chk("full_level", level, DEPTH);
    chk("full_no_overflow", overflow, 0);
    exp_q.push_back({1'b0, 4'hF, 32'hA3A2A1A0});
    drive(1'b1, 8'hA0, 1'b0);
    drive(1'b1, 8'hA1, 1'b0);
    drive(1'b1, 8'hA2, 1'b0);
    ready_cfg = 1'b1;
    drive(1'b1, 8'hA3, 1'b0);
    ready_cfg = 1'b0;
    valid = 1'b0;
    chk("pushpop_level", level, DEPTH);
    chk("pushpop_overflow", overflow, 0);
    idle(2);
    ready_cfg = 1'b1;
    wait_drain("pushpop");

    // overflow: one word too many with the consumer stalled
    ready_cfg = 1'b0;
    idle(2);
    for (int i = 0; i < DEPTH; i++) send_word(8'(8'h80 + i * 4));
    idle(1);
    chk("ovf_pre_flag", overflow, 0);
    for (int i = 0; i < 4; i++) drive(1'b1, 8'hF0 + 8'(i), 1'b0);
    idle(1);
    chk("ovf_level", level, DEPTH);
    chk("ovf_flag", overflow, 1);
    ready_cfg = 1'b1;
    wait_drain("ovf_drain");
    chk("ovf_sticky", overflow, 1);

    // reset with 3 words queued and 2 bytes packed
    ready_cfg = 1'b0;
    idle(2);
    send_word(8'hC0);
    send_word(8'hC4);
    send_word(8'hC8);
    drive(1'b1, 8'hE0, 1'b0);
    drive(1'b1, 8'hE1, 1'b0);
    valid = 1'b0;
    chk("pre_rst_level", level, 3);
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_valid", m_if.m_valid_o, 0);
    chk("mid_rst_data", m_if.m_data_o, 0);
    chk("mid_rst_keep", m_if.m_keep_o, 0);
    chk("mid_rst_last", m_if.m_last_o, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_overflow", overflow, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ready_cfg = 1'b1;
    send_word(8'h10);
    idle(1);
    wait_drain("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
